// File: rtl/csr_access_ctrl_if.sv
// rtl/csr_access_ctrl_if.sv - instruction, CSR request/response and GPR writeback bundle
//
// Purpose: groups every non-clock/reset signal of csr_access_ctrl.
//   master modport : the access controller (drives o_* signals)
//   slave modport  : decoder + CSR file + GPR writeback (drives i_* signals)
// Signals:
//   i_inst_valid/o_inst_ready  instruction handshake
//   i_funct3, i_csr_addr, i_rs1_addr_uimm, i_rd_addr, i_rs1_data  decoded fields
//   o_csr_req_valid/i_csr_req_ready, o_csr_we, o_csr_addr, o_csr_wdata  CSR request
//   i_csr_rvalid, i_csr_rdata, i_csr_err  CSR read response
//   o_rd_we, o_rd_addr, o_rd_data  GPR writeback
//   o_done, o_illegal  retire / exception pulses
interface csr_access_ctrl_if #(
   parameter int XLEN = 32
);
   logic            i_inst_valid;
   logic            o_inst_ready;
   logic [2:0]      i_funct3;
   logic [11:0]     i_csr_addr;
   logic [4:0]      i_rs1_addr_uimm;
   logic [4:0]      i_rd_addr;
   logic [XLEN-1:0] i_rs1_data;

   logic            o_csr_req_valid;
   logic            i_csr_req_ready;
   logic            o_csr_we;
   logic [11:0]     o_csr_addr;
   logic [XLEN-1:0] o_csr_wdata;
   logic            i_csr_rvalid;
   logic [XLEN-1:0] i_csr_rdata;
   logic            i_csr_err;

   logic            o_rd_we;
   logic [4:0]      o_rd_addr;
   logic [XLEN-1:0] o_rd_data;
   logic            o_done;
   logic            o_illegal;

   modport master (
      input  i_inst_valid, i_funct3, i_csr_addr, i_rs1_addr_uimm, i_rd_addr, i_rs1_data,
      input  i_csr_req_ready, i_csr_rvalid, i_csr_rdata, i_csr_err,
      output o_inst_ready, o_csr_req_valid, o_csr_we, o_csr_addr, o_csr_wdata,
      output o_rd_we, o_rd_addr, o_rd_data, o_done, o_illegal
   );

   modport slave (
      output i_inst_valid, i_funct3, i_csr_addr, i_rs1_addr_uimm, i_rd_addr, i_rs1_data,
      output i_csr_req_ready, i_csr_rvalid, i_csr_rdata, i_csr_err,
      input  o_inst_ready, o_csr_req_valid, o_csr_we, o_csr_addr, o_csr_wdata,
      input  o_rd_we, o_rd_addr, o_rd_data, o_done, o_illegal
   );
endinterface

// File: rtl/csr_access_ctrl.sv
// rtl/csr_access_ctrl.sv - Zicsr read-modify-write access controller
//
// Purpose: accepts one decoded CSR instruction, performs the optional read and
// optional write against the CSR file, returns the old CSR value to the GPR
// writeback port and flags illegal accesses.
// Ports:
//   i_clk  clock
//   i_rst  synchronous reset, active-high
//   bus    csr_access_ctrl_if.master (instruction, CSR request/response, writeback)
// Parameters:
//   XLEN      data width (32 or 64), must match the interface
//   RO_CHECK  1 = writes to CSR addresses with addr[11:10]==2'b11 are illegal
module csr_access_ctrl #(
   parameter int XLEN     = 32,
   parameter bit RO_CHECK = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   csr_access_ctrl_if.master    bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_WB,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;           // funct3[1:0]: 01 write, 10 set, 11 clear
   logic [11:0]     addr_q, addr_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] src_q, src_d;
   logic [XLEN-1:0] old_q, old_d;
   logic            need_rd_q, need_rd_d;
   logic            need_wr_q, need_wr_d;

   // Decode of the instruction presented at the input, used only on accept.
   logic            in_need_rd;
   logic            in_need_wr;
   logic            in_illegal;
   logic [XLEN-1:0] in_src;
   logic [XLEN-1:0] wdata;

   assign in_need_rd = (bus.i_funct3[1:0] != 2'b01) | (bus.i_rd_addr != 5'd0);
   assign in_need_wr = (bus.i_funct3[1:0] == 2'b01) | (bus.i_rs1_addr_uimm != 5'd0);
   // A write to a read-only CSR is illegal even when the read alone would be fine.
   assign in_illegal = (bus.i_funct3[1:0] == 2'b00) |
                       (RO_CHECK & in_need_wr & (bus.i_csr_addr[11:10] == 2'b11));
   assign in_src     = bus.i_funct3[2] ? {{(XLEN-5){1'b0}}, bus.i_rs1_addr_uimm}
                                       : bus.i_rs1_data;

   always_comb begin
      case (op_q)
         2'b10:   wdata = old_q | src_q;
         2'b11:   wdata = old_q & ~src_q;
         default: wdata = src_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      rd_d      = rd_q;
      src_d     = src_q;
      old_d     = old_q;
      need_rd_d = need_rd_q;
      need_wr_d = need_wr_q;

      bus.o_inst_ready    = 1'b0;
      bus.o_csr_req_valid = 1'b0;
      bus.o_csr_we        = 1'b0;
      bus.o_csr_addr      = 12'd0;
      bus.o_csr_wdata     = '0;
      bus.o_rd_we         = 1'b0;
      bus.o_rd_addr       = 5'd0;
      bus.o_rd_data       = '0;
      bus.o_done          = 1'b0;
      bus.o_illegal       = 1'b0;

      case (state_q)
         S_IDLE: begin
            bus.o_inst_ready = 1'b1;
            if (bus.i_inst_valid) begin
               op_d      = bus.i_funct3[1:0];
               addr_d    = bus.i_csr_addr;
               rd_d      = bus.i_rd_addr;
               src_d     = in_src;
               need_rd_d = in_need_rd;
               need_wr_d = in_need_wr;
               if (in_illegal)      state_d = S_ERR;
               else if (in_need_rd) state_d = S_RD_REQ;
               else                 state_d = S_WR_REQ;
            end
         end
         S_RD_REQ: begin
            bus.o_csr_req_valid = 1'b1;
            bus.o_csr_addr      = addr_q;
            if (bus.i_csr_req_ready) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (bus.i_csr_rvalid) begin
               old_d = bus.i_csr_rdata;
               if (bus.i_csr_err)   state_d = S_ERR;
               else if (need_wr_q)  state_d = S_WR_REQ;
               else                 state_d = S_WB;
            end
         end
         S_WR_REQ: begin
            // Posted write: completion is the handshake itself.
            bus.o_csr_req_valid = 1'b1;
            bus.o_csr_we        = 1'b1;
            bus.o_csr_addr      = addr_q;
            bus.o_csr_wdata     = wdata;
            if (bus.i_csr_req_ready) state_d = S_WB;
         end
         S_WB: begin
            bus.o_rd_we   = need_rd_q & (rd_q != 5'd0);
            bus.o_rd_addr = rd_q;
            bus.o_rd_data = old_q;
            bus.o_done    = 1'b1;
            state_d       = S_IDLE;
         end
         S_ERR: begin
            bus.o_illegal = 1'b1;
            bus.o_done    = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         op_q      <= 2'b00;
         addr_q    <= 12'd0;
         rd_q      <= 5'd0;
         src_q     <= '0;
         old_q     <= '0;
         need_rd_q <= 1'b0;
         need_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         rd_q      <= rd_d;
         src_q     <= src_d;
         old_q     <= old_d;
         need_rd_q <= need_rd_d;
         need_wr_q <= need_wr_d;
      end
   end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb/tb_csr_access_ctrl.sv - self-checking bench for csr_access_ctrl
module tb_csr_access_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   csr_access_ctrl_if #(.XLEN(32)) bus ();

   csr_access_ctrl #(.XLEN(32), .RO_CHECK(1'b1)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [4:0]  rs1u;
      logic [4:0]  rd;
      logic [31:0] rs1d;
      logic [31:0] old;
      logic        err;
      logic        exp_ill;
      int          exp_nrd;
      int          exp_nwr;
      logic [31:0] exp_wdata;
      logic        exp_rd_we;
      logic [31:0] exp_rd_data;
      int          exp_lat;
   } vec_t;

   typedef struct {
      int          lat;
      logic        ill;
      logic        rd_we;
      logic [4:0]  rd_addr;
      logic [31:0] rd_data;
      int          nrd;
      int          nwr;
      logic [31:0] wdata;
      logic [11:0] waddr;
      logic [11:0] raddr;
      int          stab;
      logic        tmo;
   } res_t;

   int checks = 0;
   int errors = 0;
   logic [31:0] csr_mem [4096];
   vec_t vecs [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the spec rules as plain arithmetic; latency is the sum of the
   // cycles each bus phase takes given the slave's ready/rvalid delays.
   function automatic vec_t model(input vec_t v, input int rdy, input int rv);
      vec_t        e;
      logic [31:0] src;
      bit          is_rw, nrd, nwr;
      e = v;
      src   = v.f3[2] ? {27'd0, v.rs1u} : v.rs1d;
      is_rw = (v.f3[1:0] == 2'b01);
      nrd   = !is_rw || (v.rd != 0);
      nwr   = is_rw || (v.rs1u != 0);
      e.exp_ill = 0; e.exp_nrd = 0; e.exp_nwr = 0; e.exp_wdata = 0;
      e.exp_rd_we = 0; e.exp_rd_data = 0; e.exp_lat = 0;
      if (v.f3[1:0] == 2'b00 || (nwr && v.addr[11:10] == 2'b11)) begin
         e.exp_ill = 1;
         e.exp_lat = 1;
      end else begin
         if (nrd) begin
            e.exp_nrd = 1;
            e.exp_lat += (rdy + 1) + (rv + 1);
         end
         if (nrd && v.err) begin
            e.exp_ill = 1;
            e.exp_lat += 1;
         end else begin
            if (nwr) begin
               e.exp_nwr = 1;
               e.exp_lat += rdy + 1;
               if (is_rw)                  e.exp_wdata = src;
               else if (v.f3[1:0] == 2'b10) e.exp_wdata = v.old | src;
               else                         e.exp_wdata = v.old & ~src;
            end
            e.exp_rd_we   = nrd && (v.rd != 0);
            e.exp_rd_data = v.old;
            e.exp_lat += 1;
         end
      end
      return e;
   endfunction

   // Issues one instruction at the next negedge and acts as the CSR file until done.
   task automatic run_inst(input vec_t v, input int rdy_dly, input int rv_dly, output res_t r);
      int          wcnt, rvcnt, cyc;
      logic        pend, fin;
      logic [11:0] p_addr;
      logic        p_we;
      logic [31:0] p_wdata, rv_data;
      r.lat = -1; r.ill = 0; r.rd_we = 0; r.rd_addr = 0; r.rd_data = 0;
      r.nrd = 0; r.nwr = 0; r.wdata = 0; r.waddr = 0; r.raddr = 0; r.stab = 0; r.tmo = 0;
      wcnt = 0; rvcnt = 0; pend = 0; fin = 0; p_addr = 0; p_we = 0; p_wdata = 0; rv_data = 0;
      csr_mem[v.addr] = v.old;
      @(negedge clk);
      chk("inst_ready_before_fire", bus.o_inst_ready, 1);
      bus.i_inst_valid    = 1'b1;
      bus.i_funct3        = v.f3;
      bus.i_csr_addr      = v.addr;
      bus.i_rs1_addr_uimm = v.rs1u;
      bus.i_rd_addr       = v.rd;
      bus.i_rs1_data      = v.rs1d;
      @(negedge clk);
      bus.i_inst_valid    = 1'b0;
      bus.i_funct3        = 3'($urandom);
      bus.i_csr_addr      = 12'($urandom);
      bus.i_rs1_addr_uimm = 5'($urandom);
      bus.i_rd_addr       = 5'($urandom);
      bus.i_rs1_data      = $urandom;
      cyc = 1;
      while (!fin) begin
         bus.i_csr_rvalid = 1'b0;
         bus.i_csr_err    = 1'b0;
         bus.i_csr_rdata  = $urandom;
         if (rvcnt > 0) begin
            rvcnt--;
            if (rvcnt == 0) begin
               bus.i_csr_rvalid = 1'b1;
               bus.i_csr_rdata  = rv_data;
               bus.i_csr_err    = v.err;
            end
         end
         if (pend && (!bus.o_csr_req_valid || bus.o_csr_addr !== p_addr ||
                      bus.o_csr_we !== p_we || bus.o_csr_wdata !== p_wdata))
            r.stab++;
         bus.i_csr_req_ready = 1'b0;
         pend = 0;
         if (bus.o_csr_req_valid) begin
            if (wcnt >= rdy_dly) begin
               bus.i_csr_req_ready = 1'b1;
               wcnt = 0;
               if (bus.o_csr_we) begin
                  r.nwr++;
                  r.wdata = bus.o_csr_wdata;
                  r.waddr = bus.o_csr_addr;
                  csr_mem[bus.o_csr_addr] = bus.o_csr_wdata;
               end else begin
                  r.nrd++;
                  r.raddr = bus.o_csr_addr;
                  rv_data = csr_mem[bus.o_csr_addr];
                  rvcnt   = rv_dly + 1;
               end
            end else begin
               wcnt++;
               pend    = 1;
               p_addr  = bus.o_csr_addr;
               p_we    = bus.o_csr_we;
               p_wdata = bus.o_csr_wdata;
            end
         end
         if (bus.o_done) begin
            r.lat     = cyc;
            r.ill     = bus.o_illegal;
            r.rd_we   = bus.o_rd_we;
            r.rd_addr = bus.o_rd_addr;
            r.rd_data = bus.o_rd_data;
            fin = 1;
         end else if (cyc >= 200) begin
            r.tmo = 1;
            fin = 1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      bus.i_csr_req_ready = 1'b0;
      bus.i_csr_rvalid    = 1'b0;
      bus.i_csr_err       = 1'b0;
   endtask

   task automatic compare(input string tag, input vec_t e, input res_t r);
      chk({tag, " timeout"}, r.tmo, 0);
      chk({tag, " illegal"}, r.ill, e.exp_ill);
      chk({tag, " latency"}, r.lat, e.exp_lat);
      chk({tag, " n_reads"}, r.nrd, e.exp_nrd);
      chk({tag, " n_writes"}, r.nwr, e.exp_nwr);
      chk({tag, " req_stable"}, r.stab, 0);
      chk({tag, " rd_we"}, r.rd_we, e.exp_rd_we);
      if (e.exp_nrd != 0) chk({tag, " read_addr"}, r.raddr, e.addr);
      if (e.exp_nwr != 0) begin
         chk({tag, " wdata"}, r.wdata, e.exp_wdata);
         chk({tag, " write_addr"}, r.waddr, e.addr);
      end
      if (e.exp_rd_we) begin
         chk({tag, " rd_addr"}, r.rd_addr, e.rd);
         chk({tag, " rd_data"}, r.rd_data, e.exp_rd_data);
      end
   endtask

   initial begin
      vec_t e;
      res_t r;
      int   seen_done;

      bus.i_inst_valid = 0; bus.i_funct3 = 0; bus.i_csr_addr = 0; bus.i_rs1_addr_uimm = 0;
      bus.i_rd_addr = 0; bus.i_rs1_data = 0; bus.i_csr_req_ready = 0; bus.i_csr_rvalid = 0;
      bus.i_csr_rdata = 0; bus.i_csr_err = 0;
      for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;

      //           f3     addr     rs1u   rd    rs1d          old           err ill nrd nwr wdata         rd_we rd_data      lat
      vecs[0]  = '{3'b001, 12'h340, 5'd1,  5'd5, 32'hDEADBEEF, 32'h12345678, 0,  0,  1,  1,  32'hDEADBEEF, 1,    32'h12345678, 4};
      vecs[1]  = '{3'b001, 12'h341, 5'd2,  5'd0, 32'hA5A5A5A5, 32'h00000001, 0,  0,  0,  1,  32'hA5A5A5A5, 0,    32'h0,        2};
      vecs[2]  = '{3'b010, 12'hB00, 5'd0,  5'd3, 32'hFFFFFFFF, 32'h00000077, 0,  0,  1,  0,  32'h0,        1,    32'h77,       3};
      vecs[3]  = '{3'b111, 12'h300, 5'd5,  5'd7, 32'hFFFFFFFF, 32'h0000000F, 0,  0,  1,  1,  32'h0000000A, 1,    32'hF,        4};
      vecs[4]  = '{3'b110, 12'h304, 5'h10, 5'd8, 32'h00000000, 32'h00000001, 0,  0,  1,  1,  32'h00000011, 1,    32'h1,        4};
      vecs[5]  = '{3'b001, 12'hF11, 5'd1,  5'd4, 32'h00000055, 32'h00000009, 0,  1,  0,  0,  32'h0,        0,    32'h0,        1};
      vecs[6]  = '{3'b010, 12'h305, 5'd3,  5'd6, 32'h00000001, 32'h00000002, 1,  1,  1,  0,  32'h0,        0,    32'h0,        3};
      vecs[7]  = '{3'b000, 12'h340, 5'd1,  5'd1, 32'h00000001, 32'h00000002, 0,  1,  0,  0,  32'h0,        0,    32'h0,        1};
      vecs[8]  = '{3'b100, 12'h340, 5'd1,  5'd1, 32'h00000001, 32'h00000002, 0,  1,  0,  0,  32'h0,        0,    32'h0,        1};
      vecs[9]  = '{3'b010, 12'hF14, 5'd0,  5'd2, 32'h00000001, 32'h00000003, 0,  0,  1,  0,  32'h0,        1,    32'h3,        3};
      vecs[10] = '{3'b011, 12'h343, 5'd9,  5'd1, 32'h0000FF00, 32'h0000FFFF, 0,  0,  1,  1,  32'h000000FF, 1,    32'hFFFF,     4};
      vecs[11] = '{3'b101, 12'h342, 5'h1F, 5'd0, 32'hFFFFFFFF, 32'h00000000, 0,  0,  0,  1,  32'h0000001F, 0,    32'h0,        2};

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset inst_ready", bus.o_inst_ready, 1);
      chk("reset req_valid", bus.o_csr_req_valid, 0);
      chk("reset csr_we", bus.o_csr_we, 0);
      chk("reset csr_addr", bus.o_csr_addr, 0);
      chk("reset csr_wdata", bus.o_csr_wdata, 0);
      chk("reset rd_we", bus.o_rd_we, 0);
      chk("reset rd_data", bus.o_rd_data, 0);
      chk("reset done", bus.o_done, 0);
      chk("reset illegal", bus.o_illegal, 0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_inst(vecs[i], 0, 0, r);
         compare($sformatf("vec%0d", i), vecs[i], r);
      end

      // Stalled slave: ready 5 cycles late, rvalid 3 cycles late.
      e = '{3'b001, 12'h340, 5'd1, 5'd5, 32'h0BADF00D, 32'h600DCAFE, 0, 0, 1, 1, 32'h0BADF00D, 1, 32'h600DCAFE, 17};
      run_inst(e, 5, 3, r);
      compare("stall", e, r);

      // Reset while waiting for the read response.
      csr_mem[12'h340] = 32'hCAFE0001;
      @(negedge clk);
      bus.i_inst_valid = 1'b1; bus.i_funct3 = 3'b010; bus.i_csr_addr = 12'h340;
      bus.i_rs1_addr_uimm = 5'd1; bus.i_rd_addr = 5'd5; bus.i_rs1_data = 32'h1;
      @(negedge clk);
      bus.i_inst_valid = 1'b0;
      chk("rstseq rd_req_valid", bus.o_csr_req_valid, 1);
      bus.i_csr_req_ready = 1'b1;
      @(negedge clk);
      bus.i_csr_req_ready = 1'b0;
      chk("rstseq busy", bus.o_inst_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstseq inst_ready", bus.o_inst_ready, 1);
      chk("rstseq req_valid", bus.o_csr_req_valid, 0);
      seen_done = bus.o_done ? 1 : 0;
      bus.i_csr_rvalid = 1'b1;
      bus.i_csr_rdata  = 32'hBAD0BAD0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.i_csr_rvalid = 1'b0;
         if (bus.o_done || bus.o_rd_we || bus.o_csr_req_valid) seen_done++;
      end
      chk("rstseq no_activity", seen_done, 0);
      chk("rstseq idle_after", bus.o_inst_ready, 1);

      // Randomized instructions against the reference model.
      for (int n = 0; n < 80; n++) begin
         vec_t v;
         int   rdy, rv;
         v.f3   = 3'($urandom_range(0, 7));
         v.addr = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
         v.rs1u = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         v.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         v.rs1d = $urandom;
         v.old  = $urandom;
         v.err  = ($urandom_range(0, 9) == 0);
         rdy    = $urandom_range(0, 3);
         rv     = $urandom_range(0, 3);
         e = model(v, rdy, rv);
         run_inst(v, rdy, rv, r);
         compare($sformatf("rand%0d", n), e, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
Initiator side of the CSR access interface, placed in the execute stage between the decoder and the CSR register file. It takes one decoded Zicsr instruction at a time and applies the spec rules that decide whether a read or write happens. It runs the read-modify-write sequence against the CSR file over a valid/ready request channel, then returns the old CSR value to the GPR writeback port. It also flags illegal CSR accesses, such as writes to read-only CSRs or CSR-file errors.

Parameters:
XLEN, 32, data width of rs1, CSR and rd data (32 or 64)
RO_CHECK, 1, 1 = flag writes to csr_addr[11:10]==2'b11 as illegal

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_inst_valid  in  1  decoded CSR instruction present
o_inst_ready  out  1  controller idle, can accept an instruction
i_funct3  in  3  CSRRW=001 CSRRS=010 CSRRC=011 CSRRWI=101 CSRRSI=110 CSRRCI=111
i_csr_addr  in  12  target CSR
i_rs1_addr_uimm  in  5  rs1 index or uimm
i_rd_addr  in  5  destination GPR
i_rs1_data  in  XLEN  rs1 value
o_csr_req_valid  out  1  request to CSR file
i_csr_req_ready  in  1  CSR file accepts request
o_csr_we  out  1  1 = write request, 0 = read request
o_csr_addr  out  12  request address
o_csr_wdata  out  XLEN  write data
i_csr_rvalid  in  1  read response valid
i_csr_rdata  in  XLEN  read response data
i_csr_err  in  1  with rvalid: CSR nonexistent/inaccessible
o_rd_we  out  1  GPR write strobe (1 cycle)
o_rd_addr  out  5  GPR index
o_rd_data  out  XLEN  old CSR value
o_done  out  1  1-cycle pulse, instruction retired
o_illegal  out  1  1-cycle pulse, illegal-instruction exception

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE. All outputs 0 except o_inst_ready=1. Any in-flight access is abandoned with no rd write and no done pulse.
- Instruction accept: a fire happens when i_inst_valid & o_inst_ready. On fire, all instruction fields are latched.
- src: i_rs1_data for funct3[2]=0; uimm zero-extended to XLEN for funct3[2]=1.
- Read and write enables:
  - need_rd = (funct3[1:0]!=01) | (rd!=0). CSRRW/CSRRWI with rd=x0 perform no read.
  - need_wr = (funct3[1:0]==01) | (rs1_addr_uimm!=0). CSRRS/CSRRC/CSRRSI/CSRRCI with zero rs1 index or zero uimm perform no write.
- Illegal funct3 (000, 100): go to ERR directly, no bus activity.
- Read-only check: if RO_CHECK and need_wr and addr[11:10]==11, go to ERR with no bus activity. This holds even though a read would be legal.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WB, ERR.
  - IDLE --fire--> ERR (illegal) | RD_REQ (need_rd) | WR_REQ (!need_rd).
  - RD_REQ: req_valid=1, we=0, addr held. On i_csr_req_ready go to RD_WAIT.
  - RD_WAIT: wait any number of cycles for i_csr_rvalid; rdata is latched as old.
    - If i_csr_err: ERR.
    - Else if need_wr: WR_REQ.
    - Else: WB.
  - WR_REQ: req_valid=1, we=1. Write is posted (no response). On ready go to WB.
  - wdata by type: RW = src; RS = old | src; RC = old & ~src.
  - WB: o_rd_we = need_rd & (rd!=0), rd_addr = rd, rd_data = old, o_done=1. Next state IDLE.
  - ERR: o_illegal=1, o_done=1, o_rd_we=0. Next state IDLE.
- o_inst_ready=1 only in IDLE. Inputs are ignored outside IDLE.
- Request stability: once req_valid is asserted, addr/we/wdata stay stable until ready. valid never drops before ready.
- i_csr_rvalid outside RD_WAIT is ignored.
- Latency with ready/rvalid both immediate (rvalid 1 cycle after ready):
  - Read+write: fire, RD_REQ, RD_WAIT, WR_REQ, WB, giving done 4 cycles after fire.
  - Read only or write only: done 3 or 2 cycles after fire.
- Back-to-back: a new fire is possible the cycle after WB/ERR.

Test Plan:
- CSRRW rd=5, rs1_data=0xDEADBEEF, addr 0x340, CSR holds 0x12345678 -> read 0x340, write 0xDEADBEEF, rd_we=1 rd_addr=5 rd_data=0x12345678, done at fire+4.
- CSRRW rd=0 -> no read request, one write request only, rd_we=0, done at fire+2. CSRRS rs1=x0 on 0xB00 -> read only, no write, no illegal.
- CSRRCI uimm=0x05, old 0x0000000F -> wdata 0x0000000A. CSRRSI uimm=0x10, old 0x1 -> wdata 0x11.
- CSRRW to 0xF11 (read-only) -> no bus request, o_illegal pulse, rd_we=0. Read with i_csr_err=1 -> ERR, no write request, o_illegal pulse.
- Stall: i_csr_req_ready held low 5 cycles, rvalid 3 cycles late -> req_valid/addr/wdata stable throughout, correct final rd_data.
- i_rst asserted in RD_WAIT -> next cycle IDLE, o_inst_ready=1, no done, late rvalid ignored.
